// File: rtl/pipemem_bus.sv
// Memory-access stage controller: runs one dreq/dack data-bus transaction per load/store and stalls earlier stages.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN (TIMEOUT sets the WAIT-cycle limit).
module pipemem_bus #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic        mwmem,
  input  logic        mrmem,
  input  logic [1:0]  msize,
  input  logic        munsigned,
  input  logic        mflush,
  output logic        mstall,
  output logic [31:0] mmo,
  output logic        madel,
  output logic        mades,
  output logic        mbuserr,
  output logic        dreq,
  output logic        dwe,
  output logic [3:0]  dbe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  input  logic        dack,
  output logic [1:0]  dbg_state
);

  // Bus handshake: dreq rises with all bus outputs and holds them stable until the
  // cycle in WAIT where dack=1 (or the timeout fires); dreq drops on that edge.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic        aligned;
  logic        req;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        ld_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        uns_q;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] ld_data;
  logic        tmo;

  always_comb begin
    aligned = 1'b1;
    case (msize)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~malu[0];
      default: aligned = (malu[1:0] == 2'b00);
    endcase
  end

  assign req       = (mrmem | mwmem) & ~mflush & aligned;
  assign madel     = mrmem & ~aligned & ~mflush;
  assign mades     = mwmem & ~aligned & ~mflush;
  assign mstall    = ((state == S_IDLE) & req) | (state == S_WAIT);
  assign dbg_state = state;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = mb;
    case (msize)
      2'b00: begin
        be_next    = 4'b0001 << malu[1:0];
        wdata_next = {4{mb[7:0]}};
      end
      2'b01: begin
        be_next    = malu[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{mb[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = mb;
      end
    endcase
  end

  // Load alignment uses the lane/size captured at issue so it does not depend on EX/MEM staying frozen.
  always_comb begin
    lane_byte = drdata[7:0];
    case (lane_q)
      2'd0:    lane_byte = drdata[7:0];
      2'd1:    lane_byte = drdata[15:8];
      2'd2:    lane_byte = drdata[23:16];
      default: lane_byte = drdata[31:24];
    endcase
    lane_half = lane_q[1] ? drdata[31:16] : drdata[15:0];
    ld_data   = drdata;
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & lane_byte[7]}}, lane_byte};
      2'b01:   ld_data = {{16{~uns_q & lane_half[15]}}, lane_half};
      default: ld_data = drdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] tcnt;

  // Counts WAIT cycles; the last permitted WAIT cycle is the one where tcnt == TIMEOUT-1.
  always_ff @(posedge clock) begin
    if (reset || state != S_WAIT) tcnt <= '0;
    else                          tcnt <= tcnt + CW'(1);
  end

  assign tmo = (tcnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      dreq    <= 1'b0;
      dwe     <= 1'b0;
      dbe     <= 4'b0000;
      daddr   <= 32'h0;
      dwdata  <= 32'h0;
      mmo     <= 32'h0;
      mbuserr <= 1'b0;
      ld_q    <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      uns_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            dreq   <= 1'b1;
            dwe    <= mwmem;
            dbe    <= be_next;
            daddr  <= {malu[31:2], 2'b00};
            dwdata <= wdata_next;
            ld_q   <= mrmem & ~mwmem;
            size_q <= msize;
            lane_q <= malu[1:0];
            uns_q  <= munsigned;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dack) begin
            dreq  <= 1'b0;
            if (ld_q) mmo <= ld_data;
            state <= S_DONE;
          end else if (tmo) begin
            dreq    <= 1'b0;
            mbuserr <= 1'b1;
            if (ld_q) mmo <= 32'h0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          mbuserr <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
